serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Parametrised bit-serial N-bit subtractor computing D = A - B - Bin, LSB first, through one registered full-subtractor slice per clock. It generalises the single-bit full subtractor to a WIDTH-bit word with a start/busy/done handshake and a registered borrow chain. It trades latency (WIDTH cycles) for a single slice of logic and is used where area matters more than throughput.

Parameters:
WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
A  input  WIDTH  minuend; captured on the accepted start edge
B  input  WIDTH  subtrahend; captured on the accepted start edge
Bin  input  1  borrow-in; captured on the accepted start edge
D  output  WIDTH  registered difference; holds last result
Bout  output  1  registered final borrow-out; holds last result
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when D/Bout update

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). While rst=1 at a clk edge: state=IDLE, D=0, Bout=0, busy=0, done=0, counter=0, borrow register=0, shift registers=0. rst overrides start.
- States:
  - IDLE: on start=1, load shift registers a_sr<=A, b_sr<=B, br<=Bin, cnt<=0, busy<=1, and go to SHIFT.
  - SHIFT: each edge processes bit a_sr[0], b_sr[0], br:
    - d = a^b^br
    - bo = (~a & b) | (~(a^b) & br)
    - d shifts into the MSB of the result shift register (right shift); a_sr and b_sr shift right; br<=bo; cnt<=cnt+1.
  - When cnt==WIDTH-1 (last bit): D<=final result word, Bout<=bo, done<=1, busy<=0, and go to IDLE.
- Counter width is clog2(WIDTH). D is a separate output register; intermediate shift contents are never visible on D.
- Latency: start sampled at edge 0, done high after edge WIDTH for exactly one cycle. busy is high from edge 0 through edge WIDTH-1 and falls on the same edge done rises.
- done is 0 in every other cycle. D and Bout hold their values until the next done.
- start while busy=1 is ignored; operands are not re-captured.
- start in the cycle done=1 is accepted (state is IDLE), giving back-to-back operations with one op every WIDTH+1 cycles.
- A, B and Bin may change freely after the capture edge without affecting the result.
- Arithmetic: {Bout,D} = {1'b0,A} - {1'b0,B} - Bin, modulo 2^(WIDTH+1). Bout=1 iff A < B+Bin, unsigned.
- Reset mid-operation: the operation is aborted, no done pulse is produced, and all outputs go to their reset values on that edge.

Optional Feature:
Macro SUB_OVF_EN.
- Defined: adds output port V (1 bit), the registered two's-complement overflow flag. V = borrow into the MSB XOR borrow out of the MSB, captured at the last SHIFT edge alongside D. V resets to 0 and holds until the next done.
- Undefined: port V and its logic do not exist; all other behaviour is identical.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with start=1 -> D=0, Bout=0, busy=0, done=0 throughout; no operation starts.
2. WIDTH=8: A=8'h5A, B=8'h3C, Bin=0, start pulsed for 1 cycle -> busy high for 8 cycles, done pulses exactly 8 edges after the start edge, D=8'h1E, Bout=0. D keeps its prior value until done.
3. A=8'h10, B=8'h20, Bin=1 -> D=8'hEF, Bout=1. Then A=8'hFF, B=8'hFF, Bin=1 -> D=8'hFF, Bout=1. Then A=8'h00, B=8'h00, Bin=0 -> D=8'h00, Bout=0.
4. Handshake:
   - start op A=8'h05, B=8'h03; at cycle 3 pulse start with A=8'hAA, B=8'h01 -> ignored, result D=8'h02.
   - Assert start in the done cycle with A=8'h09, B=8'h04 -> accepted, D=8'h05 after the next 8 edges.
5. Reset mid-op: start A=8'h5A, B=8'h3C; assert rst at cycle 4 -> busy=0 on the next edge, done never pulses, D=0, Bout=0. A fresh start afterwards completes correctly.
6. With SUB_OVF_EN defined:
   - A=8'h80, B=8'h01, Bin=0 -> D=8'h7F, Bout=0, V=1.
   - A=8'h7F, B=8'hFF -> D=8'h80, Bout=1, V=1.
   - A=8'h05, B=8'h03 -> V=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: {Bout,D} = A - B - Bin, one bit per clock, LSB first.
// Optional macro SUB_OVF_EN adds the registered two's-complement overflow output V.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset (overrides start)
//   start - request, sampled only while idle
//   A, B  - minuend / subtrahend, captured on the accepted start edge
//   Bin   - borrow-in, captured on the accepted start edge
//   D     - registered difference, holds last result
//   Bout  - registered final borrow-out, holds last result
//   busy  - high while an operation is in progress
//   done  - one-cycle pulse on the edge D/Bout update
//   V     - (SUB_OVF_EN only) registered signed overflow flag

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             busy,
   output logic             done
`ifdef SUB_OVF_EN
   ,
   output logic             V
`endif
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] a_sr, a_n;
   logic [WIDTH-1:0] b_sr, b_n;
   logic [WIDTH-1:0] d_sr, d_n;
   logic             br, br_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] dout_n;
   logic             bout_n;
   logic             busy_n;
   logic             done_n;
`ifdef SUB_OVF_EN
   logic             v_n;
`endif

   // Single full-subtractor slice on the current LSBs.
   logic a_bit, b_bit, d_bit, bo;

   always_comb begin
      a_bit = a_sr[0];
      b_bit = b_sr[0];
      d_bit = a_bit ^ b_bit ^ br;
      bo    = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
   end

   always_comb begin
      state_n = state;
      a_n     = a_sr;
      b_n     = b_sr;
      d_n     = d_sr;
      br_n    = br;
      cnt_n   = cnt;
      dout_n  = D;
      bout_n  = Bout;
      busy_n  = busy;
      done_n  = 1'b0;
`ifdef SUB_OVF_EN
      v_n     = V;
`endif
      unique case (state)
         IDLE: begin
            if (start) begin
               a_n     = A;
               b_n     = B;
               br_n    = Bin;
               d_n     = '0;
               cnt_n   = '0;
               busy_n  = 1'b1;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            a_n   = a_sr >> 1;
            b_n   = b_sr >> 1;
            // New difference bit enters at the MSB; after WIDTH shifts
            // bit 0 of the word sits at bit 0.
            d_n   = (d_sr >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
            br_n  = bo;
            cnt_n = cnt + 1'b1;
            if (cnt == LAST) begin
               dout_n  = d_n;
               bout_n  = bo;
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = IDLE;
`ifdef SUB_OVF_EN
               // br is the borrow into the MSB, bo the borrow out of it.
               v_n     = br ^ bo;
`endif
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_sr  <= '0;
         b_sr  <= '0;
         d_sr  <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         D     <= '0;
         Bout  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef SUB_OVF_EN
         V     <= 1'b0;
`endif
      end else begin
         state <= state_n;
         a_sr  <= a_n;
         b_sr  <= b_n;
         d_sr  <= d_n;
         br    <= br_n;
         cnt   <= cnt_n;
         D     <= dout_n;
         Bout  <= bout_n;
         busy  <= busy_n;
         done  <= done_n;
`ifdef SUB_OVF_EN
         V     <= v_n;
`endif
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, handshake,
// mid-op reset and randomized operands against an arithmetic model.

module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Bin;
   logic [W-1:0] D;
   logic         Bout;
   logic         busy;
   logic         done;
`ifdef SUB_OVF_EN
   logic         V;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   logic [W-1:0] last_d;
   logic         last_bo;
   logic         last_v;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .Bin   (Bin),
      .D     (D),
      .Bout  (Bout),
      .busy  (busy),
      .done  (done)
`ifdef SUB_OVF_EN
      ,
      .V     (V)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Unsigned difference with borrow, modulo 2^(W+1).
   function automatic logic [W:0] model(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic bin);
      logic [W:0] r;
      r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
      return r;
   endfunction

   // Signed overflow: true result outside the W-bit signed range.
   function automatic logic model_v(input logic [W-1:0] a,
                                    input logic [W-1:0] b,
                                    input logic bin);
      int sa, sb, s;
      sa = int'($signed(a));
      sb = int'($signed(b));
      s  = sa - sb - int'(bin);
      return (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
   endfunction

   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bin);
      A     = a;
      B     = b;
      Bin   = bin;
      start = 1'b1;
      tick();
      start = 1'b0;
      // Operands are free to move once captured.
      A     = W'($urandom);
      B     = W'($urandom);
      Bin   = 1'($urandom);
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("done_after_start", 32'(done), 32'd0);
   endtask

   // Runs the remaining W edges of an op; leaves time just after done.
   task automatic finish(input logic [W-1:0] ed, input logic eb,
                         input logic ev, input int glitch_at);
      for (int k = 1; k <= W; k++) begin
         tick();
         if (k < W) begin
            chk("busy_mid", 32'(busy), 32'd1);
            chk("done_mid", 32'(done), 32'd0);
            chk("d_hold", 32'(D), 32'(last_d));
            chk("bout_hold", 32'(Bout), 32'(last_bo));
         end else begin
            chk("done_pulse", 32'(done), 32'd1);
            chk("busy_fall", 32'(busy), 32'd0);
            chk("d_result", 32'(D), 32'(ed));
            chk("bout_result", 32'(Bout), 32'(eb));
`ifdef SUB_OVF_EN
            chk("v_result", 32'(V), 32'(ev));
`endif
            last_d  = ed;
            last_bo = eb;
            last_v  = ev;
         end
         if (glitch_at != 0 && k == glitch_at) begin
            start = 1'b1;
            A     = 8'hAA;
            B     = 8'h01;
         end
         if (glitch_at != 0 && k == glitch_at + 1) start = 1'b0;
      end
      start = 1'b0;
   endtask

   task automatic idle_check();
      tick();
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("d_idle_hold", 32'(D), 32'(last_d));
   endtask

   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic bin);
      logic [W:0] r;
      r = model(a, b, bin);
      launch(a, b, bin);
      finish(r[W-1:0], r[W], model_v(a, b, bin), 0);
      idle_check();
   endtask

   initial begin
      logic [W:0]   r;
      logic [W-1:0] ra, rb;
      logic         rbin;

      rst     = 1'b1;
      start   = 1'b1;
      A       = 8'h5A;
      B       = 8'h3C;
      Bin     = 1'b0;
      last_d  = '0;
      last_bo = 1'b0;
      last_v  = 1'b0;

      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_d", 32'(D), 32'd0);
         chk("rst_bout", 32'(Bout), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_done", 32'(done), 32'd0);
`ifdef SUB_OVF_EN
         chk("rst_v", 32'(V), 32'd0);
`endif
      end
      rst   = 1'b0;
      start = 1'b0;
      tick();
      chk("no_start_busy", 32'(busy), 32'd0);
      chk("no_start_done", 32'(done), 32'd0);

      launch(8'h5A, 8'h3C, 1'b0);
      finish(8'h1E, 1'b0, 1'b0, 0);
      idle_check();

      launch(8'h10, 8'h20, 1'b1);
      finish(8'hEF, 1'b1, 1'b0, 0);
      idle_check();
      launch(8'hFF, 8'hFF, 1'b1);
      finish(8'hFF, 1'b1, 1'b0, 0);
      idle_check();
      launch(8'h00, 8'h00, 1'b0);
      finish(8'h00, 1'b0, 1'b0, 0);
      idle_check();

      launch(8'h05, 8'h03, 1'b0);
      finish(8'h02, 1'b0, 1'b0, 3);
      launch(8'h09, 8'h04, 1'b0);
      finish(8'h05, 1'b0, 1'b0, 0);
      idle_check();

      launch(8'h5A, 8'h3C, 1'b0);
      for (int k = 1; k < 4; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_d", 32'(D), 32'd0);
      chk("abort_bout", 32'(Bout), 32'd0);
      last_d  = '0;
      last_bo = 1'b0;
      last_v  = 1'b0;
      for (int k = 0; k < W + 2; k++) begin
         tick();
         chk("abort_no_done", 32'(done), 32'd0);
         chk("abort_idle", 32'(busy), 32'd0);
      end
      launch(8'h5A, 8'h3C, 1'b0);
      finish(8'h1E, 1'b0, 1'b0, 0);
      idle_check();

      launch(8'h80, 8'h01, 1'b0);
      finish(8'h7F, 1'b0, 1'b1, 0);
      idle_check();
      launch(8'h7F, 8'hFF, 1'b0);
      finish(8'h80, 1'b1, 1'b1, 0);
      idle_check();
      launch(8'h05, 8'h03, 1'b0);
      finish(8'h02, 1'b0, 1'b0, 0);
      idle_check();

      for (int i = 0; i < 24; i++) begin
         ra   = W'($urandom);
         rb   = W'($urandom);
         rbin = 1'($urandom);
         r    = model(ra, rb, rbin);
         launch(ra, rb, rbin);
         finish(r[W-1:0], r[W], model_v(ra, rb, rbin),
                (i % 3 == 0) ? int'($urandom_range(1, W - 2)) : 0);
         if (i % 2 == 0) idle_check();
      end

      op(8'hFF, 8'h00, 1'b1);
      op(8'h00, 8'hFF, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
